// File: rtl/fwd_hazard_scoreboard.sv
// fwd_hazard_scoreboard: EX operand forwarding, load-use/scoreboard stall and multi-cycle watchdog.
// Optional perf counters enabled by defining FWD_PERF_CNT_EN.
module fwd_hazard_scoreboard #(
  parameter int NUM_READ   = 3,
  parameter int NUM_STAGES = 2,
  parameter int MC_TIMEOUT = 64,
  parameter int SEL_W      = $clog2(NUM_STAGES+1)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_READ*5-1:0]   rs_addr,
  input  logic [NUM_READ-1:0]     rs_used,
  input  logic [NUM_STAGES*5-1:0] src_rd,
  input  logic [NUM_STAGES-1:0]   src_we,
  input  logic [NUM_STAGES-1:0]   src_ready,
  input  logic                    issue_valid,
  input  logic [4:0]              issue_rd,
  input  logic                    issue_mc,
  input  logic                    flush,
  input  logic                    mc_wb_valid,
  input  logic [4:0]              mc_wb_rd,
  output logic [NUM_READ*SEL_W-1:0] fwd_sel,
  output logic                    stall,
  output logic                    mc_busy,
`ifdef FWD_PERF_CNT_EN
  output logic [31:0]             perf_stall_cycles,
  output logic [31:0]             perf_fwd_hits,
`endif
  output logic                    mc_err
);
  localparam int CW = $clog2(MC_TIMEOUT+1);
  logic [31:0]   pending_q, pending_d;
  logic          busy_q, busy_d, err_q, err_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [4:0]    rs;
  logic          hit, lu_stall, raw, waw, strct, mc_set;
  always_comb begin
    fwd_sel  = '0;
    lu_stall = 1'b0;
    raw      = 1'b0;
    rs       = '0;
    hit      = 1'b0;
    for (int p = 0; p < NUM_READ; p++) begin
      rs  = rs_addr[p*5 +: 5];
      hit = 1'b0;
      if (rs_used[p] && rs != 5'd0) begin
        // youngest matching stage wins; an unready winner stalls rather than falling back to an older copy
        for (int s = 0; s < NUM_STAGES; s++) begin
          if (!hit && src_we[s] && src_rd[s*5 +: 5] == rs) begin
            hit = 1'b1;
            fwd_sel[p*SEL_W +: SEL_W] = SEL_W'(s+1);
            lu_stall = lu_stall | ~src_ready[s];
          end
        end
        raw = raw | pending_q[rs];
      end
    end
  end
  assign waw    = pending_q[issue_rd];
  assign strct  = issue_mc & busy_q & ~mc_wb_valid;
  assign stall  = issue_valid & ~flush & (lu_stall | raw | waw | strct);
  assign mc_set = issue_valid & ~flush & ~stall & issue_mc;
  always_comb begin
    pending_d = pending_q;
    if (mc_wb_valid) pending_d[mc_wb_rd] = 1'b0;
    if (mc_set) pending_d[issue_rd] = 1'b1;
    pending_d[0] = 1'b0;
    busy_d = mc_set | (busy_q & ~mc_wb_valid);
    cnt_d  = (!busy_q || mc_set || mc_wb_valid) ? '0 :
             (cnt_q == CW'(MC_TIMEOUT)) ? cnt_q : cnt_q + CW'(1);
    err_d  = err_q | (cnt_d == CW'(MC_TIMEOUT));
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q <= '0;
      busy_q    <= 1'b0;
      cnt_q     <= '0;
      err_q     <= 1'b0;
    end else begin
      pending_q <= pending_d;
      busy_q    <= busy_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
    end
  end
  assign mc_busy = busy_q;
  assign mc_err  = err_q;
`ifdef FWD_PERF_CNT_EN
  logic [31:0] stall_cnt_q, hit_cnt_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      hit_cnt_q   <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_q + {31'd0, stall};
      hit_cnt_q   <= hit_cnt_q + {31'd0, (|fwd_sel) & ~stall};
    end
  end
  assign perf_stall_cycles = stall_cnt_q;
  assign perf_fwd_hits     = hit_cnt_q;
`endif
endmodule

// File: tb/tb_fwd_hazard_scoreboard.sv
// tb_fwd_hazard_scoreboard: directed checks of forwarding, stalls, scoreboard and watchdog (MC_TIMEOUT=4).
module tb_fwd_hazard_scoreboard;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [14:0] rs_addr;
  logic [2:0]  rs_used;
  logic [9:0]  src_rd;
  logic [1:0]  src_we, src_ready;
  logic        issue_valid, issue_mc, flush, mc_wb_valid;
  logic [4:0]  issue_rd, mc_wb_rd;
  logic [5:0]  fwd_sel;
  logic        stall, mc_busy, mc_err;
  int          n_pass = 0, n_tot = 0;
`ifdef FWD_PERF_CNT_EN
  logic [31:0] perf_stall_cycles, perf_fwd_hits;
`endif

  fwd_hazard_scoreboard #(.NUM_READ(3), .NUM_STAGES(2), .MC_TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n), .rs_addr(rs_addr), .rs_used(rs_used),
    .src_rd(src_rd), .src_we(src_we), .src_ready(src_ready),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_mc(issue_mc),
    .flush(flush), .mc_wb_valid(mc_wb_valid), .mc_wb_rd(mc_wb_rd),
    .fwd_sel(fwd_sel), .stall(stall), .mc_busy(mc_busy),
`ifdef FWD_PERF_CNT_EN
    .perf_stall_cycles(perf_stall_cycles), .perf_fwd_hits(perf_fwd_hits),
`endif
    .mc_err(mc_err));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tot++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic idle();
    rs_addr = '0; rs_used = '0; src_rd = '0; src_we = '0; src_ready = '0;
    issue_valid = 1'b0; issue_rd = '0; issue_mc = 1'b0; flush = 1'b0;
    mc_wb_valid = 1'b0; mc_wb_rd = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue_mc_op(input logic [4:0] rd);
    idle();
    issue_valid = 1'b1; issue_mc = 1'b1; issue_rd = rd;
  endtask

  initial begin
    idle();
    #1;
    chk("rst_busy", {31'd0, mc_busy}, 32'd0);
    chk("rst_err", {31'd0, mc_err}, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("idle_stall", {31'd0, stall}, 32'd0);
    chk("idle_fwd", {26'd0, fwd_sel}, 32'd0);
    chk("idle_busy", {31'd0, mc_busy}, 32'd0);
    // forwarding priority
    issue_valid = 1'b1; issue_rd = 5'd1;
    rs_used = 3'b001; rs_addr = {5'd0, 5'd0, 5'd5};
    src_rd = {5'd5, 5'd5}; src_we = 2'b11; src_ready = 2'b11;
    #1;
    chk("prio_sel0", {30'd0, fwd_sel[1:0]}, 32'd1);
    chk("prio_stall", {31'd0, stall}, 32'd0);
    src_we = 2'b10;
    #1;
    chk("older_sel0", {30'd0, fwd_sel[1:0]}, 32'd2);
    // load-use
    rs_used = 3'b010; rs_addr = {5'd0, 5'd7, 5'd0};
    src_rd = {5'd0, 5'd7}; src_we = 2'b01; src_ready = 2'b00;
    #1;
    chk("lu_stall", {31'd0, stall}, 32'd1);
    chk("lu_sel1", {30'd0, fwd_sel[3:2]}, 32'd1);
    tick();
    src_rd = {5'd7, 5'd0}; src_we = 2'b10; src_ready = 2'b10;
    #1;
    chk("lu_sel1_next", {30'd0, fwd_sel[3:2]}, 32'd2);
    chk("lu_nostall", {31'd0, stall}, 32'd0);
    // x0 and unused ports
    rs_used = 3'b111; rs_addr = '0; src_rd = '0; src_we = 2'b11; src_ready = 2'b11;
    #1;
    chk("x0_sel", {26'd0, fwd_sel}, 32'd0);
    rs_used = 3'b100; rs_addr = {5'd5, 5'd5, 5'd5}; src_rd = {5'd0, 5'd5}; src_we = 2'b01;
    #1;
    chk("unused_sel", {26'd0, fwd_sel}, {26'd0, 6'b010000});
    // multi-cycle RAW / WAW / structural
    tick();
    issue_mc_op(5'd9);
    #1;
    chk("mc_issue_stall", {31'd0, stall}, 32'd0);
    tick();
    chk("mc_busy_set", {31'd0, mc_busy}, 32'd1);
    idle();
    issue_valid = 1'b1; issue_rd = 5'd1; rs_used = 3'b001; rs_addr = {10'd0, 5'd9};
    #1;
    chk("raw_stall", {31'd0, stall}, 32'd1);
    rs_used = 3'b000; issue_rd = 5'd9;
    #1;
    chk("waw_stall", {31'd0, stall}, 32'd1);
    issue_rd = 5'd11; issue_mc = 1'b1;
    #1;
    chk("struct_stall", {31'd0, stall}, 32'd1);
    flush = 1'b1;
    #1;
    chk("flush_nostall", {31'd0, stall}, 32'd0);
    flush = 1'b0; issue_mc = 1'b0; issue_rd = 5'd1; rs_used = 3'b001;
    mc_wb_valid = 1'b1; mc_wb_rd = 5'd9;
    #1;
    chk("wb_same_cycle_stall", {31'd0, stall}, 32'd1);
    tick();
    mc_wb_valid = 1'b0;
    #1;
    chk("wb_next_nostall", {31'd0, stall}, 32'd0);
    chk("wb_busy_clr", {31'd0, mc_busy}, 32'd0);
    // back-to-back multi-cycle
    issue_mc_op(5'd9);
    tick();
    issue_mc_op(5'd10);
    mc_wb_valid = 1'b1; mc_wb_rd = 5'd9;
    #1;
    chk("b2b_nostall", {31'd0, stall}, 32'd0);
    tick();
    chk("b2b_busy", {31'd0, mc_busy}, 32'd1);
    idle();
    issue_valid = 1'b1; issue_rd = 5'd1; rs_used = 3'b001; rs_addr = {10'd0, 5'd9};
    #1;
    chk("b2b_x9_free", {31'd0, stall}, 32'd0);
    rs_addr = {10'd0, 5'd10};
    #1;
    chk("b2b_x10_pend", {31'd0, stall}, 32'd1);
    idle();
    mc_wb_valid = 1'b1; mc_wb_rd = 5'd10;
    tick();
    // flushed second op instead
    issue_mc_op(5'd9);
    tick();
    issue_mc_op(5'd10);
    flush = 1'b1; mc_wb_valid = 1'b1; mc_wb_rd = 5'd9;
    tick();
    chk("flush_busy_fall", {31'd0, mc_busy}, 32'd0);
    idle();
    issue_valid = 1'b1; issue_rd = 5'd1; rs_used = 3'b001; rs_addr = {10'd0, 5'd10};
    #1;
    chk("flush_x10_free", {31'd0, stall}, 32'd0);
    // watchdog
    issue_mc_op(5'd12);
    tick();
    idle();
    tick();
    tick();
    tick();
    chk("wd_err_early", {31'd0, mc_err}, 32'd0);
    tick();
    chk("wd_err_set", {31'd0, mc_err}, 32'd1);
    mc_wb_valid = 1'b1; mc_wb_rd = 5'd12;
    tick();
    idle();
    chk("wd_busy_clr", {31'd0, mc_busy}, 32'd0);
    chk("wd_err_sticky", {31'd0, mc_err}, 32'd1);
    // async reset mid-op
    issue_mc_op(5'd13);
    tick();
    idle();
    issue_valid = 1'b1; issue_rd = 5'd1; rs_used = 3'b001; rs_addr = {10'd0, 5'd13};
    #1;
    chk("pre_rst_busy", {31'd0, mc_busy}, 32'd1);
    chk("pre_rst_raw", {31'd0, stall}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_busy", {31'd0, mc_busy}, 32'd0);
    chk("rst_mid_err", {31'd0, mc_err}, 32'd0);
    chk("rst_mid_pend", {31'd0, stall}, 32'd0);
    tick();
    rst_n = 1'b1;
    mc_wb_valid = 1'b1; mc_wb_rd = 5'd13;
    tick();
    chk("post_rst_wb_busy", {31'd0, mc_busy}, 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
